tune_sequencer: RTL

Melody sequencer that drives the `pwm_audio` tone generator. It holds a small programmable note table, where each entry is a period divisor `N`, a duration and a last flag. On `start` it steps through the table autonomously and presents `N` plus a `gate` that enables the speaker output (`AIN`). It replaces button-driven note selection in the top level with timed playback, and inserts a silent articulation gap between notes.

---
 rtl/tune_sequencer_pkg.sv | 21 ++
 rtl/tune_sequencer_if.sv | 32 +++
 rtl/tune_sequencer_tick_prescaler.sv | 28 ++
 rtl/tune_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tune_sequencer_pkg.sv
// Shared types and widths for the tune sequencer: FSM states, table entry layout.
package tune_seq_pkg;

  localparam int NOTE_W = 10;
  localparam int DUR_W  = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
    logic              last;
  } entry_t;

endpackage

// File: rtl/tune_sequencer_if.sv
// Control, table-write and playback-status bundle between a host and tune_sequencer.
interface tune_sequencer_if #(
  parameter int DEPTH = 16
);
  import tune_seq_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic              start;
  logic              stop;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NOTE_W-1:0] wr_note;
  logic [DUR_W-1:0]  wr_dur;
  logic              wr_last;
  logic [NOTE_W-1:0] N;
  logic              gate;
  logic              busy;
  logic              done;
  logic [AW-1:0]     cur_idx;

  modport master (
    output start, stop, wr_en, wr_addr, wr_note, wr_dur, wr_last,
    input  N, gate, busy, done, cur_idx
  );

  modport slave (
    input  start, stop, wr_en, wr_addr, wr_note, wr_dur, wr_last,
    output N, gate, busy, done, cur_idx
  );

endinterface

// File: rtl/tune_sequencer_tick_prescaler.sv
// Divides the system clock into one-cycle duration ticks every TICK_DIV cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_o = !clear_i && (cnt_q == CW'(TICK_DIV - 1));

  // The count never passes TICK_DIV-1: it restarts there, or on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/tune_sequencer.sv
// Timed melody playback from a programmable note table, feeding pwm_audio.
// Optional TUNE_SEQ_LOOP_EN adds a 'loop' input that restarts the tune instead of ending it.
module tune_sequencer
  import tune_seq_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 10,
  parameter int DEPTH     = 16
) (
  input logic clk,
  input logic rst,
`ifdef TUNE_SEQ_LOOP_EN
  input logic loop,
`endif
  tune_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  entry_t            table_q [DEPTH];
  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic [NOTE_W-1:0] n_q;
  logic              gate_q;
  logic              busy_q;
  logic              done_q;
  logic [DUR_W-1:0]  workDur_q;
  logic              workLast_q;
  logic [DUR_W-1:0]  ticks_q;

  entry_t        rdEntry;
  logic          tick;
  logic          wrap;
  logic          playEnd;
  logic          gapEnd;
  logic          entryExit;
  logic          endOfTune;
  logic          goDone;
  state_e        endState;
  logic [AW-1:0] endIdx;

  function automatic logic [DUR_W-1:0] satInc(input logic [DUR_W-1:0] v);
    return (&v) ? v : v + DUR_W'(1);
  endfunction

`ifdef TUNE_SEQ_LOOP_EN
  assign wrap = loop;
`else
  assign wrap = 1'b0;
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == LOAD),
    .tick_o  (tick)
  );

  // Writes land with non-blocking timing, so a same-cycle LOAD still sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (bus.wr_en) begin
      table_q[bus.wr_addr] <= '{note: bus.wr_note, dur: bus.wr_dur, last: bus.wr_last};
    end
  end

  assign rdEntry = table_q[idx_q];
  assign playEnd = tick && (ticks_q == workDur_q - DUR_W'(1));
  assign gapEnd  = tick && (ticks_q == DUR_W'(GAP_TICKS - 1));

  // End-of-entry decision folded into whichever state finishes the entry.
  always_comb begin
    entryExit = 1'b0;
    case (state_q)
      LOAD:    entryExit = (rdEntry.dur == '0);
      PLAY:    entryExit = playEnd && (GAP_TICKS == 0);
      GAP:     entryExit = gapEnd;
      default: entryExit = 1'b0;
    endcase
    endOfTune = ((state_q == LOAD) ? rdEntry.last : workLast_q) || (idx_q == AW'(DEPTH - 1));
    goDone    = endOfTune && !wrap;
    endState  = goDone ? DONE : LOAD;
    endIdx    = goDone ? idx_q : (endOfTune ? '0 : idx_q + AW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      workDur_q  <= '0;
      workLast_q <= 1'b0;
      ticks_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && bus.stop) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        gate_q  <= 1'b0;
        n_q     <= '0;
      end else if (entryExit) begin
        state_q <= endState;
        idx_q   <= endIdx;
        done_q  <= goDone;
        gate_q  <= 1'b0;
        ticks_q <= '0;
        if (goDone) n_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start && !bus.stop) begin
              state_q <= LOAD;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          LOAD: begin
            workDur_q  <= rdEntry.dur;
            workLast_q <= rdEntry.last;
            ticks_q    <= '0;
            n_q        <= rdEntry.note;
            gate_q     <= (rdEntry.note != '0);
            state_q    <= PLAY;
          end
          PLAY: begin
            if (playEnd) begin
              state_q <= GAP;
              gate_q  <= 1'b0;
              ticks_q <= '0;
            end else if (tick) begin
              ticks_q <= satInc(ticks_q);
            end
          end
          GAP: begin
            if (tick) ticks_q <= satInc(ticks_q);
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.N       = n_q;
  assign bus.gate    = gate_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cur_idx = idx_q;

endmodule
